// File: rtl/packed_result_fifo.sv
// Packs {data, ctrl, zero pad} per accepted beat into a DEPTH-entry first-word-fall-through FIFO.
// One cycle store-to-head latency; back-pressures when full unless drop_mode, which drops and counts instead.
module packed_result_fifo #(
  parameter int DATA_W = 8,
  parameter int CTRL_W = 4,
  parameter int PAD_W  = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8,
  localparam int OUT_W = DATA_W + CTRL_W + PAD_W,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              drop_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              status_nz,
  output logic [LVL_W-1:0]  level,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int PAY_W = DATA_W + CTRL_W;

  logic [PAY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic [CNT_W-1:0] drop_q;
  logic             nz_q;
  logic             full;
  logic             push;
  logic             pop;
  logic             store;
  logic             drop;
  logic [PAY_W-1:0] head;

  assign full     = (level_q == LVL_W'(DEPTH));
  assign in_ready = drop_mode ? !clr : (!full && !clr);
  assign push     = in_valid && in_ready && !clr;
  assign out_valid = (level_q != '0);
  assign pop      = out_valid && out_ready && !clr;
  assign store    = push && !full;
  // Full-time push only reaches here in drop_mode; a same-cycle pop does not rescue it.
  assign drop     = push && full;

  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr] <= {in_data, in_ctrl};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      drop_q  <= '0;
      nz_q    <= 1'b0;
    end else if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      drop_q  <= '0;
      nz_q    <= 1'b0;
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        nz_q   <= |in_data;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level_q <= level_q + LVL_W'(store) - LVL_W'(pop);
      if (drop && (drop_q != {CNT_W{1'b1}})) begin
        drop_q <= drop_q + CNT_W'(1);
      end
    end
  end

  assign head = mem[rd_ptr];

  generate
    if (PAD_W > 0) begin : g_pad
      assign out_data = out_valid ? {head, {PAD_W{1'b0}}} : '0;
    end else begin : g_nopad
      assign out_data = out_valid ? head : '0;
    end
  endgenerate

  assign status_nz = nz_q;
  assign level     = level_q;
  assign drop_cnt  = drop_q;

endmodule
